fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the instruction-fetch path: owns the program counter, issues requests to instruction memory with a ready handshake, and presents fetched words to the decode/execute stage.
- Handles start, halt, branch/jump redirect and memory timeout, replacing the free-running PC+4 register.
- Sits between the instruction memory and the processor datapath.

Parameters:
ADDR_W, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, PC loaded on reset and on start from IDLE
PC_STEP, 4, sequential PC increment in bytes
MAX_WAIT, 16, maximum cycles in FETCH without imem_ready before error (≥1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  leave IDLE/HALT and begin fetching
halt_req  in  1  stop after the next accepted instruction
redirect_valid  in  1  branch/jump target present
redirect_pc  in  ADDR_W  branch/jump target
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address (= pc)
imem_ready  in  1  imem_rdata valid for the current request
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instr/instr_pc valid for downstream
instr  out  32  captured instruction
instr_pc  out  ADDR_W  address of instr
instr_accept  in  1  downstream consumes instr this cycle
pc  out  ADDR_W  current fetch PC
busy  out  1  state is FETCH or ISSUE
halted  out  1  state is HALT
fetch_err  out  1  sticky error flag

Behaviour:
- States: IDLE, FETCH, ISSUE, HALT, ERR. All registers are async-cleared on rst_n=0: state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, wait counter=0, halt_pend=0, redir_pend=0. All outputs 0 except pc=imem_addr=RESET_PC. imem_req drops immediately on reset, including mid-fetch.
- IDLE: start=1 -> FETCH, pc=RESET_PC. halt_req and redirect are ignored.
- FETCH: imem_req=1, imem_addr=pc, held until imem_ready. Wait counter increments each cycle without ready. Counter reaching MAX_WAIT -> ERR. On imem_ready with no pending redirect: instr<=imem_rdata, instr_pc<=pc -> ISSUE; instr_valid rises the next cycle, so minimum fetch-to-valid latency is 1 cycle after ready. Counter clears on leaving FETCH.
- Redirect during FETCH: target latched into redir_pend; a later redirect overwrites it. The returned word is discarded (no ISSUE). At the ready cycle: pc<=target, redir_pend clears, state stays FETCH with a new request the next cycle.
- ISSUE: instr_valid=1, instr and instr_pc held stable until instr_accept. On accept, next pc uses this priority: redirect_valid this cycle, else redir_pend, else pc+PC_STEP. The add wraps modulo 2^ADDR_W.
  - Then -> HALT if halt_pend or halt_req, else -> FETCH.
  - Redirect without accept -> latched, applied at accept.
- halt_req in FETCH/ISSUE sets halt_pend; it clears on entering HALT.
- HALT: halted=1, pc holds the next address. start -> FETCH resuming at pc.
- ERR: fetch_err=1, imem_req=0, instr_valid=0. Only reset exits.
- Simultaneous accept + redirect + halt_req: pc=redirect target, -> HALT, and the resume fetch goes to the target.
- start in FETCH/ISSUE/ERR: ignored.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined: a redirect with target[1:0]≠0 (latched or applied) -> ERR at that cycle, fetch_err=1, pc unchanged.
- Undefined: target[1:0] forced to 2'b00 and no error.

Test Plan:
- Reset, start, imem_ready 1 cycle after every req, accept immediately -> imem_addr 0x0,0x4,0x8,0xC; instr_pc matches; busy=1.
- imem_ready delayed 3 cycles, instr_accept delayed 2 cycles -> imem_req stays high 3 cycles; instr/instr_pc stable while instr_valid=1 and not accepted.
- Redirect 0x40 coincident with accept of instr_pc 0x8 -> next imem_addr 0x40, then 0x44. Redirect 0x80 during FETCH of 0xC -> word for 0xC never presented; next fetch 0x80.
- halt_req during FETCH of 0x10, accept -> halted=1, pc=0x14, no imem_req. Then start -> fetch 0x14.
- imem_ready never asserted with MAX_WAIT=16 -> fetch_err=1 after 16 FETCH cycles, imem_req=0. rst_n low mid-fetch -> outputs cleared asynchronously, pc=RESET_PC.
- With FETCH_ALIGN_CHECK_EN, redirect 0x42 -> fetch_err=1. Without it -> next fetch 0x40.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch bus between fetch_sequencer, instruction memory and decode.
// master = sequencer side, slave = memory/decode side.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_accept;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ready, imem_rdata, instr_accept
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ready, imem_rdata, instr_accept
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches from instruction memory, presents words downstream.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise fetch_err instead of being masked.
module fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4,
  parameter int                MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_sequencer_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fetch_err,
  output logic [2:0]        dbg_state
);
  // Handshakes: imem_req holds with a stable imem_addr until the cycle imem_ready is high
  // (that cycle's imem_rdata is the reply); instr_valid holds with stable instr/instr_pc
  // until the cycle instr_accept is high, which is the transfer cycle.

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_HALT  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  wait_cnt;
  logic              halt_pend;
  logic              redir_pend;
  logic [ADDR_W-1:0] redir_pc_q;
  logic [ADDR_W-1:0] redir_tgt;
  logic              redir_bad;
  logic              timeout;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              req_o, valid_o;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_tgt = redirect_pc;
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00)
                     && ((state == S_FETCH) || (state == S_ISSUE));
`else
  assign redir_tgt = redirect_pc & ~ADDR_W'(3);
  assign redir_bad = 1'b0;
`endif

  assign timeout = (state == S_FETCH) && !bus.imem_ready
                   && (wait_cnt == CNT_W'(MAX_WAIT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: begin
        if (redir_bad || timeout) state_nx = S_ERR;
        else if (bus.imem_ready && !redirect_valid && !redir_pend) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        if (redir_bad) state_nx = S_ERR;
        else if (bus.instr_accept) state_nx = (halt_pend || halt_req) ? S_HALT : S_FETCH;
      end
      S_HALT:  if (start) state_nx = S_FETCH;
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_o     = 1'b0;
    valid_o   = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    fetch_err = 1'b0;
    case (state)
      S_FETCH: begin req_o = 1'b1; busy = 1'b1; end
      S_ISSUE: begin valid_o = 1'b1; busy = 1'b1; end
      S_HALT:  halted = 1'b1;
      S_ERR:   fetch_err = 1'b1;
      default: ;
    endcase
  end

  assign bus.imem_req    = req_o;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid_o;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign dbg_state       = state;

  // PC, captured instruction, wait counter and pending redirect/halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      wait_cnt   <= '0;
      halt_pend  <= 1'b0;
      redir_pend <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) pc <= RESET_PC;
        S_FETCH: begin
          if (redir_bad) begin
            wait_cnt <= '0;
          end else begin
            if (halt_req) halt_pend <= 1'b1;
            if (bus.imem_ready) begin
              wait_cnt <= '0;
              // A redirect seen during this fetch kills the returned word
              if (redirect_valid) begin
                pc         <= redir_tgt;
                redir_pend <= 1'b0;
              end else if (redir_pend) begin
                pc         <= redir_pc_q;
                redir_pend <= 1'b0;
              end else begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc;
              end
            end else begin
              wait_cnt <= timeout ? '0 : wait_cnt + 1'b1;
              if (redirect_valid) begin
                redir_pend <= 1'b1;
                redir_pc_q <= redir_tgt;
              end
            end
          end
        end
        S_ISSUE: begin
          if (!redir_bad) begin
            if (bus.instr_accept) begin
              if (redirect_valid)  pc <= redir_tgt;
              else if (redir_pend) pc <= redir_pc_q;
              else                 pc <= pc + ADDR_W'(PC_STEP);
              redir_pend <= 1'b0;
              halt_pend  <= 1'b0;
            end else begin
              if (halt_req) halt_pend <= 1'b1;
              if (redirect_valid) begin
                redir_pend <= 1'b1;
                redir_pc_q <= redir_tgt;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_fetch_sequencer;
  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              halt_req = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [ADDR_W-1:0] pc;
  logic              busy, halted, fetch_err;
  logic [2:0]        dbg_state;

  int vectors = 0;
  int errors  = 0;
  logic [63:0] exp_q[$];

  fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_sequencer #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bus(bus), .pc(pc), .busy(busy), .halted(halted),
    .fetch_err(fetch_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, miscompares so far %0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    bus.imem_ready = 1'b0; bus.instr_accept = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  // ---------------- driver tasks ----------------
  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (bus.imem_req !== 1'b1) begin
      tick();
      n++;
      if (n > 40) begin ok = 1'b0; break; end
    end
  endtask

  task automatic serve_fetch(input int delay, output bit ok, output logic [31:0] addr);
    wait_req(ok);
    addr = bus.imem_addr;
    if (!ok) return;
    repeat (delay) tick();
    bus.imem_ready = 1'b1;
    bus.imem_rdata = mem_word(bus.imem_addr);
    tick();
    bus.imem_ready = 1'b0;
  endtask

  task automatic take_instr(input int delay, input bit redir, input logic [31:0] rpc,
                            input bit hreq, output bit ok,
                            output logic [31:0] w, output logic [31:0] a);
    int n = 0;
    ok = 1'b1;
    while (bus.instr_valid !== 1'b1) begin
      tick();
      n++;
      if (n > 40) begin ok = 1'b0; break; end
    end
    w = bus.instr;
    a = bus.instr_pc;
    if (!ok) return;
    repeat (delay) tick();
    bus.instr_accept = 1'b1;
    redirect_valid   = redir;
    redirect_pc      = rpc;
    halt_req         = hreq;
    tick();
    bus.instr_accept = 1'b0;
    redirect_valid   = 1'b0;
    halt_req         = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    vectors++;
    if (pc !== 32'h0 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_pc: pc=%h addr=%h required 0", pc, bus.imem_addr);
    end
    vectors++;
    if ({bus.imem_req, bus.instr_valid, busy, halted, fetch_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 00000",
                         {bus.imem_req, bus.instr_valid, busy, halted, fetch_err});
    end
    vectors++;
    if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
      errors++; $display("FAIL reset_instr: instr=%h instr_pc=%h required 0", bus.instr, bus.instr_pc);
    end
    apply_reset();
    tick();
    vectors++;
    if (bus.imem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: req=%b busy=%b required 0", bus.imem_req, busy);
    end
  endtask

  task automatic test_sequential();
    bit ok; logic [31:0] a, w, ipc;
    apply_reset();
    kick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (busy !== 1'b1) begin errors++; $display("FAIL seq_busy: busy=%b required 1", busy); end
      serve_fetch(1, ok, a);
      vectors++;
      if (!ok || a !== 32'(i * 4)) begin
        errors++; $display("FAIL seq_addr: ok=%0d addr=%h required %h", ok, a, 32'(i * 4));
      end
      take_instr(0, 1'b0, 32'h0, 1'b0, ok, w, ipc);
      vectors++;
      if (!ok || ipc !== 32'(i * 4) || w !== mem_word(32'(i * 4))) begin
        errors++; $display("FAIL seq_instr: instr_pc=%h instr=%h required %h %h",
                           ipc, w, 32'(i * 4), mem_word(32'(i * 4)));
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    apply_reset();
    kick();
    wait_req(ok);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (!ok || bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
        errors++; $display("FAIL stall_req: cycle %0d req=%b valid=%b addr=%h required 1 0 0",
                           k, bus.imem_req, bus.instr_valid, bus.imem_addr);
      end
      tick();
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = mem_word(bus.imem_addr);
    tick();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== mem_word(32'h0) || bus.instr_pc !== 32'h0) begin
        errors++; $display("FAIL stall_hold: cycle %0d valid=%b instr=%h pc=%h required 1 %h 0",
                           k, bus.instr_valid, bus.instr, bus.instr_pc, mem_word(32'h0));
      end
      if (k < 2) tick();
    end
    bus.instr_accept = 1'b1;
    tick();
    bus.instr_accept = 1'b0;
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
      errors++; $display("FAIL stall_next: req=%b addr=%h required 1 4", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_redirect();
    bit ok; logic [31:0] a, w, ipc;
    apply_reset();
    kick();
    for (int i = 0; i < 3; i++) begin
      serve_fetch(1, ok, a);
      take_instr(0, (i == 2), 32'h40, 1'b0, ok, w, ipc);
    end
    serve_fetch(0, ok, a);
    vectors++;
    if (!ok || a !== 32'h40) begin errors++; $display("FAIL redir_accept: addr=%h required 40", a); end
    take_instr(0, 1'b0, 32'h0, 1'b0, ok, w, ipc);
    serve_fetch(0, ok, a);
    vectors++;
    if (!ok || a !== 32'h44) begin errors++; $display("FAIL redir_seq: addr=%h required 44", a); end
    take_instr(1, 1'b0, 32'h0, 1'b0, ok, w, ipc);
    wait_req(ok);
    vectors++;
    if (!ok || bus.imem_addr !== 32'h48) begin
      errors++; $display("FAIL redir_pre: addr=%h required 48", bus.imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    tick();
    bus.imem_ready = 1'b1;
    bus.imem_rdata = mem_word(bus.imem_addr);
    tick();
    bus.imem_ready = 1'b0;
    vectors++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin
      errors++; $display("FAIL redir_fetch: valid=%b req=%b addr=%h required 0 1 80",
                         bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    serve_fetch(0, ok, a);
    take_instr(0, 1'b0, 32'h0, 1'b0, ok, w, ipc);
    vectors++;
    if (!ok || ipc !== 32'h80 || w !== mem_word(32'h80)) begin
      errors++; $display("FAIL redir_word: instr_pc=%h instr=%h required 80 %h", ipc, w, mem_word(32'h80));
    end
  endtask

  task automatic test_halt();
    bit ok; logic [31:0] a, w, ipc;
    apply_reset();
    kick();
    for (int i = 0; i < 4; i++) begin
      serve_fetch(1, ok, a);
      take_instr(0, 1'b0, 32'h0, 1'b0, ok, w, ipc);
    end
    wait_req(ok);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = mem_word(bus.imem_addr);
    tick();
    bus.imem_ready = 1'b0;
    take_instr(0, 1'b0, 32'h0, 1'b0, ok, w, ipc);
    vectors++;
    if (!ok || ipc !== 32'h10) begin errors++; $display("FAIL halt_instr: instr_pc=%h required 10", ipc); end
    vectors++;
    if (halted !== 1'b1 || pc !== 32'h14 || bus.imem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL halt_state: halted=%b pc=%h req=%b busy=%b required 1 14 0 0",
                         halted, pc, bus.imem_req, busy);
    end
    repeat (3) tick();
    vectors++;
    if (halted !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL halt_hold: halted=%b req=%b required 1 0", halted, bus.imem_req);
    end
    kick();
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14) begin
      errors++; $display("FAIL halt_resume: req=%b addr=%h required 1 14", bus.imem_req, bus.imem_addr);
    end
    serve_fetch(0, ok, a);
    take_instr(0, 1'b1, 32'h200, 1'b1, ok, w, ipc);
    vectors++;
    if (halted !== 1'b1 || pc !== 32'h200) begin
      errors++; $display("FAIL halt_combo: halted=%b pc=%h required 1 200", halted, pc);
    end
    kick();
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      errors++; $display("FAIL halt_combo_resume: req=%b addr=%h required 1 200", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_timeout();
    bit ok; logic [31:0] a, w, ipc;
    int n = 0;
    apply_reset();
    kick();
    while (bus.imem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    vectors++;
    if (n !== MAX_WAIT) begin errors++; $display("FAIL timeout_cycles: got %0d required %0d", n, MAX_WAIT); end
    vectors++;
    if (fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_err: err=%b req=%b valid=%b busy=%b required 1 0 0 0",
                         fetch_err, bus.imem_req, bus.instr_valid, busy);
    end
    kick();
    tick();
    vectors++;
    if (fetch_err !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL err_sticky: err=%b req=%b required 1 0", fetch_err, bus.imem_req);
    end
    apply_reset();
    kick();
    serve_fetch(0, ok, a);
    take_instr(0, 1'b0, 32'h0, 1'b0, ok, w, ipc);
    wait_req(ok);
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.imem_req !== 1'b0 || pc !== 32'h0 || bus.imem_addr !== 32'h0 || busy !== 1'b0 || fetch_err !== 1'b0) begin
      errors++; $display("FAIL async_reset: req=%b pc=%h addr=%h busy=%b err=%b required 0 0 0 0 0",
                         bus.imem_req, pc, bus.imem_addr, busy, fetch_err);
    end
    vectors++;
    if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset_instr: instr=%h pc=%h valid=%b required 0 0 0",
                         bus.instr, bus.instr_pc, bus.instr_valid);
    end
    apply_reset();
  endtask

  task automatic test_align();
    bit ok; logic [31:0] a, w, ipc;
    apply_reset();
    kick();
    serve_fetch(0, ok, a);
    take_instr(0, 1'b1, 32'h42, 1'b0, ok, w, ipc);
    vectors++;
`ifdef FETCH_ALIGN_CHECK_EN
    if (fetch_err !== 1'b1 || pc !== 32'h0 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL align_err: err=%b pc=%h req=%b required 1 0 0", fetch_err, pc, bus.imem_req);
    end
`else
    if (fetch_err !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      errors++; $display("FAIL align_mask: err=%b req=%b addr=%h required 0 1 40",
                         fetch_err, bus.imem_req, bus.imem_addr);
    end
`endif
  endtask

  task automatic test_wrap();
    bit ok; logic [31:0] a, w, ipc;
    apply_reset();
    kick();
    serve_fetch(0, ok, a);
    take_instr(0, 1'b1, 32'hFFFF_FFFC, 1'b0, ok, w, ipc);
    serve_fetch(0, ok, a);
    take_instr(0, 1'b0, 32'h0, 1'b0, ok, w, ipc);
    vectors++;
    if (!ok || ipc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr: instr_pc=%h required fffffffc", ipc); end
    wait_req(ok);
    vectors++;
    if (!ok || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: addr=%h required 0", bus.imem_addr); end
  endtask

  task automatic test_random();
    logic [31:0] m_fetch, m_pend;
    bit m_pend_v, m_halt;
    int m_next, stall;
    logic [63:0] e;
    apply_reset();
    kick();
    exp_q.delete();
    m_fetch = 32'h0; m_pend = 32'h0; m_pend_v = 1'b0; m_halt = 1'b0;
    m_next = 1; stall = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      bus.imem_ready   = bus.imem_req && (($urandom_range(0, 99) < 60) || stall >= 8);
      bus.imem_rdata   = mem_word(bus.imem_addr);
      bus.instr_accept = bus.instr_valid && ($urandom_range(0, 99) < 50);
      redirect_valid   = (bus.imem_req || bus.instr_valid) && ($urandom_range(0, 99) < 8);
      redirect_pc      = 32'($urandom_range(0, 1023)) << 2;
      halt_req         = (bus.imem_req || bus.instr_valid) && ($urandom_range(0, 99) < 4);
      start            = halted && ($urandom_range(0, 99) < 25);
      if (m_next == 1) begin
        vectors++;
        if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rnd_fetch: cycle %0d req=%b required 1", cyc, bus.imem_req); end
      end else if (m_next == 2) begin
        vectors++;
        if (halted !== 1'b1 || bus.imem_req !== 1'b0 || pc !== m_fetch) begin
          errors++; $display("FAIL rnd_halt: cycle %0d halted=%b req=%b pc=%h required 1 0 %h",
                             cyc, halted, bus.imem_req, pc, m_fetch);
        end
      end
      m_next = 0;
      if (bus.imem_req === 1'b1) begin
        stall = bus.imem_ready ? 0 : stall + 1;
        if (halt_req) m_halt = 1'b1;
        if (bus.imem_ready) begin
          vectors++;
          if (bus.imem_addr !== m_fetch || bus.instr_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_addr: cycle %0d addr=%h valid=%b required %h 0",
                               cyc, bus.imem_addr, bus.instr_valid, m_fetch);
          end
          if (redirect_valid || m_pend_v) begin
            m_fetch = redirect_valid ? redirect_pc : m_pend;
            m_next  = 1;
          end else begin
            exp_q.push_back({m_fetch, mem_word(m_fetch)});
          end
          m_pend_v = 1'b0;
        end else if (redirect_valid) begin
          m_pend_v = 1'b1; m_pend = redirect_pc;
        end
      end else if (bus.instr_valid === 1'b1) begin
        if (bus.instr_accept) begin
          vectors++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL rnd_spurious: cycle %0d instr_pc=%h presented with none expected", cyc, bus.instr_pc);
          end else begin
            e = exp_q.pop_front();
            if ({bus.instr_pc, bus.instr} !== e) begin
              errors++; $display("FAIL rnd_instr: cycle %0d got %h_%h required %h_%h",
                                 cyc, bus.instr_pc, bus.instr, e[63:32], e[31:0]);
            end
          end
          m_fetch  = redirect_valid ? redirect_pc : (m_pend_v ? m_pend : m_fetch + 32'd4);
          m_pend_v = 1'b0;
          m_next   = (m_halt || halt_req) ? 2 : 1;
          m_halt   = 1'b0;
        end else begin
          if (halt_req) m_halt = 1'b1;
          if (redirect_valid) begin m_pend_v = 1'b1; m_pend = redirect_pc; end
        end
      end else if (halted === 1'b1) begin
        if (start) m_next = 1;
      end
      tick();
    end
    bus.imem_ready = 1'b0; bus.instr_accept = 1'b0;
    redirect_valid = 1'b0; halt_req = 1'b0; start = 1'b0;
    vectors++;
    if (fetch_err !== 1'b0) begin errors++; $display("FAIL rnd_err: fetch_err=%b required 0", fetch_err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.imem_ready   = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.instr_accept = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_timeout();
    test_align();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
